// File: rtl/mem_req_ctrl_if.sv
// Core-side load/store channel of mem_req_ctrl: a request valid/ready
// channel and a response valid/ready channel carrying load data.
interface mem_req_ctrl_if #(
    parameter int WORD = 32,
    parameter int ADDR = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [ADDR-1:0] req_addr;
    logic [WORD-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [WORD-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Request-side controller for a single-port synchronous memory: drives the
// memory pins from the request port and returns load data via a credited FIFO.
module mem_req_ctrl #(
    parameter int WORD      = 32,
    parameter int ADDR      = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_req_ctrl_if.slave   bus,
    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic            rd_pend;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [WORD-1:0] fifo_mem [RSP_DEPTH];

    logic [CW:0]     credit_used;
    logic            accept;
    logic            push;
    logic            pop;

    // Credit covers both stored entries and the load whose data arrives this
    // cycle; pops are deliberately not credited so rsp_ready never reaches req_ready.
    assign credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend};
    assign bus.req_ready = !rst && (credit_used < DEPTH_C);
    assign accept        = bus.req_valid && bus.req_ready;

    assign mem_A = bus.req_addr;
    assign mem_D = bus.req_wdata;
    assign mem_W = accept && bus.req_we;

    assign push          = rd_pend;
    assign bus.rsp_valid = (fifo_count != '0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.rsp_rdata = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            rd_pend <= accept && !bus.req_we;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is never cleared; a returning load is simply dropped under reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= mem_Q;
        end
    end
endmodule
